// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - first-word-fall-through key FIFO with sticky overflow and drop/overwrite full policy
module key_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int OVW_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       kv,
    input  logic [DATA_W-1:0]          kd,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       occ;
    logic              ovf_q;

    logic              is_full;
    logic              is_empty;
    logic              do_push;
    logic              do_pop;
    logic              ovr_hit;
    logic              overwrite;
    logic              wr_en;
    logic              head_adv;

    // Decode push/pop/overflow qualifiers from the current occupancy.
    // A push into a full FIFO is only an overflow when no pop frees a slot
    // in the same cycle; overwrite mode then recycles the oldest slot.
    always_comb begin
        is_full   = (occ == CNT_FULL);
        is_empty  = (occ == '0);
        do_pop    = rd_en && !is_empty;
        do_push   = kv && (!is_full || rd_en);
        ovr_hit   = kv && is_full && !rd_en;
        overwrite = ovr_hit && (OVW_MODE != 0);
        wr_en     = do_push || overwrite;
        head_adv  = do_pop || overwrite;
    end

    // Storage is not reset; pointers define which words are live.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[tail] <= kd;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            occ   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_en) begin
                tail <= tail + PTR_ONE;
            end
            if (head_adv) begin
                head <= head + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: occ <= occ;
            endcase
            // A new overflow wins over a coincident clear.
            if (ovr_hit) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign rd_valid = !is_empty;
    assign rd_data  = is_empty ? '0 : mem[head];
    assign count    = occ;
    assign full     = is_full;
    assign empty    = is_empty;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_key_fifo.sv
// tb/tb_key_fifo.sv - randomized and directed self-checking bench for key_fifo in drop and overwrite modes
module tb_key_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       kv = 1'b0;
    logic [7:0] kd = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;

    logic       rd_valid0, full0, empty0, ovf0;
    logic [7:0] rd_data0;
    logic [2:0] count0;
    logic       rd_valid1, full1, empty1, ovf1;
    logic [7:0] rd_data1;
    logic [2:0] count1;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq [2][$];
    bit         mo [2];

    always #5 clk = ~clk;

    key_fifo #(.DATA_W(8), .DEPTH(4), .OVW_MODE(0)) dut_drop (
        .clk(clk), .rst(rst), .kv(kv), .kd(kd), .rd_en(rd_en),
        .rd_valid(rd_valid0), .rd_data(rd_data0), .count(count0),
        .full(full0), .empty(empty0), .ovf(ovf0), .clr_ovf(clr_ovf)
    );

    key_fifo #(.DATA_W(8), .DEPTH(4), .OVW_MODE(1)) dut_ovw (
        .clk(clk), .rst(rst), .kv(kv), .kd(kd), .rd_en(rd_en),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .count(count1),
        .full(full1), .empty(empty1), .ovf(ovf1), .clr_ovf(clr_ovf)
    );

    // Queue model: pop first (only if something is there), then push; a push
    // into a full queue with no pop is an overflow that drops or recycles.
    task automatic model_update(input bit r, input bit k, input logic [7:0] d,
                                input bit p, input bit c);
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                mq[m].delete();
                mo[m] = 1'b0;
            end else begin
                bit evt;
                evt = k && (mq[m].size() == 4) && !p;
                if (evt) begin
                    if (m == 1) begin
                        void'(mq[m].pop_front());
                        mq[m].push_back(d);
                    end
                end else begin
                    if (p && mq[m].size() > 0) void'(mq[m].pop_front());
                    if (k) mq[m].push_back(d);
                end
                if (evt) mo[m] = 1'b1;
                else if (c) mo[m] = 1'b0;
            end
        end
    endtask

    function automatic logic [14:0] exp_vec(input int m);
        int sz;
        logic [7:0] hd;
        sz = mq[m].size();
        hd = (sz != 0) ? mq[m][0] : 8'h00;
        return {sz != 0, hd, 3'(sz), sz == 4, sz == 0, mo[m]};
    endfunction

    task automatic step(input bit r, input bit k, input logic [7:0] d,
                        input bit p, input bit c);
        rst = r; kv = k; kd = d; rd_en = p; clr_ovf = c;
        @(posedge clk);
        model_update(r, k, d, p, c);
        @(negedge clk);
        rst = 1'b0; kv = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic test_reset;
        step(1, 0, 8'h00, 0, 0);
        checks++;
        if ({rd_valid0, rd_data0, count0, full0, empty0, ovf0} !== 15'b0_00000000_000_0_1_0) begin
            failures++;
            $display("FAIL reset_drop got=%b exp=%b", {rd_valid0, rd_data0, count0, full0, empty0, ovf0}, 15'b0_00000000_000_0_1_0);
        end
        checks++;
        if ({rd_valid1, rd_data1, count1, full1, empty1, ovf1} !== 15'b0_00000000_000_0_1_0) begin
            failures++;
            $display("FAIL reset_ovw got=%b exp=%b", {rd_valid1, rd_data1, count1, full1, empty1, ovf1}, 15'b0_00000000_000_0_1_0);
        end
    endtask

    task automatic test_push_pop;
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'h12, 0, 0);
        checks++;
        if ({rd_valid0, rd_data0, count0} !== {1'b1, 8'h12, 3'd1}) begin
            failures++;
            $display("FAIL push_one got=%h exp=%h", {rd_valid0, rd_data0, count0}, {1'b1, 8'h12, 3'd1});
        end
        step(0, 0, 8'h00, 1, 0);
        checks++;
        if ({empty0, rd_data0} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL pop_one got=%h exp=%h", {empty0, rd_data0}, {1'b1, 8'h00});
        end
    endtask

    task automatic test_full_policy;
        step(1, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 8'(i), 0, 0);
        checks++;
        if ({full0, ovf0, count0} !== {1'b1, 1'b1, 3'd4}) begin
            failures++;
            $display("FAIL drop_full_ovf got=%b exp=%b", {full0, ovf0, count0}, {1'b1, 1'b1, 3'd4});
        end
        checks++;
        if ({full1, ovf1, count1} !== {1'b1, 1'b1, 3'd4}) begin
            failures++;
            $display("FAIL ovw_full_ovf got=%b exp=%b", {full1, ovf1, count1}, {1'b1, 1'b1, 3'd4});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data0 !== 8'(i + 1)) begin
                failures++;
                $display("FAIL drop_order[%0d] got=%h exp=%h", i, rd_data0, 8'(i + 1));
            end
            checks++;
            if (rd_data1 !== 8'(i + 2)) begin
                failures++;
                $display("FAIL ovw_order[%0d] got=%h exp=%h", i, rd_data1, 8'(i + 2));
            end
            step(0, 0, 8'h00, 1, 0);
        end
    endtask

    task automatic test_full_push_pop;
        step(1, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, 8'(i), 0, 0);
        checks++;
        if (rd_data0 !== 8'h01) begin
            failures++;
            $display("FAIL fpp_head_before got=%h exp=%h", rd_data0, 8'h01);
        end
        step(0, 1, 8'h09, 1, 0);
        checks++;
        if ({count0, ovf0, rd_data0} !== {3'd4, 1'b0, 8'h02}) begin
            failures++;
            $display("FAIL fpp_drop got=%h exp=%h", {count0, ovf0, rd_data0}, {3'd4, 1'b0, 8'h02});
        end
        checks++;
        if ({count1, ovf1, rd_data1} !== {3'd4, 1'b0, 8'h02}) begin
            failures++;
            $display("FAIL fpp_ovw got=%h exp=%h", {count1, ovf1, rd_data1}, {3'd4, 1'b0, 8'h02});
        end
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);
        checks++;
        if ({rd_data0, rd_data1, count0} !== {8'h09, 8'h09, 3'd1}) begin
            failures++;
            $display("FAIL fpp_last got=%h exp=%h", {rd_data0, rd_data1, count0}, {8'h09, 8'h09, 3'd1});
        end
    endtask

    task automatic test_empty_push_pop;
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'h33, 1, 0);
        checks++;
        if ({count0, rd_data0, count1, rd_data1} !== {3'd1, 8'h33, 3'd1, 8'h33}) begin
            failures++;
            $display("FAIL epp_push got=%h exp=%h", {count0, rd_data0, count1, rd_data1}, {3'd1, 8'h33, 3'd1, 8'h33});
        end
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        checks++;
        if ({count0, empty0, rd_valid0, rd_data0} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL epp_underflow got=%h exp=%h", {count0, empty0, rd_valid0, rd_data0}, {3'd0, 1'b1, 1'b0, 8'h00});
        end
    endtask

    task automatic test_clr_ovf;
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hA0 + i), 0, 0);
        step(0, 1, 8'hAF, 0, 1);
        checks++;
        if ({ovf0, ovf1} !== 2'b11) begin
            failures++;
            $display("FAIL clr_vs_ovf got=%b exp=%b", {ovf0, ovf1}, 2'b11);
        end
        step(0, 0, 8'h00, 0, 1);
        checks++;
        if ({ovf0, ovf1, count0} !== {2'b00, 3'd4}) begin
            failures++;
            $display("FAIL clr_only got=%b exp=%b", {ovf0, ovf1, count0}, {2'b00, 3'd4});
        end
    endtask

    task automatic test_reset_mid;
        step(1, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
        step(0, 0, 8'h00, 1, 0);
        checks++;
        if ({count0, ovf0} !== {3'd3, 1'b1}) begin
            failures++;
            $display("FAIL mid_pre got=%b exp=%b", {count0, ovf0}, {3'd3, 1'b1});
        end
        step(1, 1, 8'h77, 0, 0);
        checks++;
        if ({count0, ovf0, empty0, count1, ovf1, empty1} !== {3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mid_rst got=%b exp=%b", {count0, ovf0, empty0, count1, ovf1, empty1}, {3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1});
        end
        step(0, 1, 8'($urandom), 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 8'($urandom), 1, 0);
            checks++;
            if ({rd_valid0, rd_data0, count0, full0, empty0, ovf0} !== exp_vec(0)) begin
                failures++;
                $display("FAIL wrap[%0d] got=%b exp=%b", i, {rd_valid0, rd_data0, count0, full0, empty0, ovf0}, exp_vec(0));
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            checks++;
            if ({rd_valid0, rd_data0, count0, full0, empty0, ovf0} !== exp_vec(0)) begin
                failures++;
                $display("FAIL rand_drop[%0d] got=%b exp=%b", i, {rd_valid0, rd_data0, count0, full0, empty0, ovf0}, exp_vec(0));
            end
            checks++;
            if ({rd_valid1, rd_data1, count1, full1, empty1, ovf1} !== exp_vec(1)) begin
                failures++;
                $display("FAIL rand_ovw[%0d] got=%b exp=%b", i, {rd_valid1, rd_data1, count1, full1, empty1, ovf1}, exp_vec(1));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_push_pop();
        test_full_policy();
        test_full_push_pop();
        test_empty_push_pop();
        test_clr_ovf();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_fifo.md
KEY_FIFO -- requirements
Module: key_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the key/data word width (matches kd).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the entry count; a power of two, at least 2.
REQ-003 The block SHALL have parameter OVW_MODE, default 0, meaning the full policy: 0 drops the new word, 1 overwrites the oldest word.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port kv, input, 1, meaning the producer key-valid push strobe.
REQ-007 The block SHALL have port kd, input, DATA_W, meaning the producer key data, sampled when kv=1.
REQ-008 The block SHALL have port rd_en, input, 1, meaning the CPU pop strobe.
REQ-009 The block SHALL have port rd_valid, output, 1, meaning the head word is present.
REQ-010 The block SHALL have port rd_data, output, DATA_W, meaning the head word in first-word-fall-through form.
REQ-011 The block SHALL have port count, output, log2(DEPTH)+1, meaning the current occupancy.
REQ-012 The block SHALL have ports full and empty, outputs, 1 each, meaning count==DEPTH and count==0.
REQ-013 The block SHALL have port ovf, output, 1, meaning the sticky overflow flag.
REQ-014 The block SHALL have port clr_ovf, input, 1, meaning clear ovf.

Function
REQ-015 The block SHALL hold data in a circular buffer with head and tail pointers of log2(DEPTH) bits; pointers wrap DEPTH-1 -> 0.
REQ-016 The block SHALL drive rd_valid = !empty and rd_data = mem[head] combinationally, with rd_data = 0 when empty.
REQ-017 A push (kv=1, not full) SHALL write kd at tail, advance tail, and increment count; the word is visible on rd_data on the next cycle if the FIFO was empty.
REQ-018 A pop (rd_en=1, not empty) SHALL advance head and decrement count; rd_en while empty SHALL be ignored with no state change.
REQ-019 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-020 Simultaneous push and pop when empty SHALL accept the push only (count 0->1).
REQ-021 Simultaneous push and pop when full SHALL perform both (count stays DEPTH) and SHALL NOT set ovf.
REQ-022 A push when full without pop, OVW_MODE=0, SHALL discard kd, leave pointers and count unchanged, and set ovf.
REQ-023 A push when full without pop, OVW_MODE=1, SHALL write kd at tail, advance both head and tail, keep count=DEPTH, and set ovf.
REQ-024 ovf SHALL remain set until clr_ovf=1; if clr_ovf and a new overflow coincide, ovf SHALL remain 1.
REQ-025 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set head=0, tail=0, count=0, and ovf=0, giving empty=1, full=0, rd_valid=0, and rd_data=0 on the following cycle.
REQ-027 rst SHALL override kv, rd_en, and clr_ovf in the same cycle; storage contents need not be reset.
REQ-028 Reset asserted mid-operation (FIFO partially full) SHALL discard all stored words.

Verification (DATA_W=8, DEPTH=4)
REQ-029 Reset, then push 0x12 -> next cycle rd_valid=1, rd_data=0x12, count=1; pop -> empty=1, rd_data=0.
REQ-030 Push 0x01..0x04, then push 0x05 with OVW_MODE=0 -> full=1, ovf=1; pops return 0x01,0x02,0x03,0x04.
REQ-031 Same stimulus with OVW_MODE=1 -> ovf=1, count=4; pops return 0x02,0x03,0x04,0x05.
REQ-032 Full FIFO, push 0x09 and pop in the same cycle -> count=4, ovf=0, head word was 0x01 and is now 0x02; last word popped is 0x09.
REQ-033 Empty FIFO, kv=1 with kd=0x33 and rd_en=1 together -> count=1, rd_data=0x33; a separate rd_en while empty -> no change.
REQ-034 Fill 3 words with ovf set, then assert rst together with kv=1 -> count=0, ovf=0, empty=1; 10 wrap-around push/pop cycles preserve data order.
